flb_therm_ramp_decoder: RTL
===========================

# flb_therm_ramp_decoder

Parametrised, registered successor of the FLB row binary-to-thermometer decoder. It drives a 2D serpentine DCO unit-cell matrix of 2^ROW_W rows by 2^COL_W columns from one binary tuning code. A valid/ready handshake loads a new code. The internal applied code slews toward the target by at most STEP_MAX cells per clock, so the array never jumps by more than STEP_MAX cells in one cycle. All decoded outputs are registered and glitch-free. The block sits between the DPLL loop filter output and the FLB cell array.

## Interface
- ROW_W, 4, row-select bits; matrix has 2^ROW_W rows
- COL_W, 4, column-select bits; matrix has 2^COL_W columns; N = ROW_W+COL_W
- STEP_MAX, 1, maximum change of applied code per clock; legal range 1 .. 2^N-1
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- code_i  input  N  target code (number of cells on); MSBs = row R, LSBs = column c
- code_valid_i  input  1  code_i is valid
- code_ready_o  output  1  block idle and able to accept a code
- ramp_en_i  input  1  1: slew-limited ramp; 0: jump straight to target
- hold_i  input  1  1: freeze the applied code; handshake is still accepted
- row_full_o  output  2^ROW_W  bit r = 1 iff r < R (row fully on)
- row_act_o  output  2^ROW_W  one-hot, bit R = partially filled row enable
- col_o  output  2^COL_W  column lines for the active row
- row_odd_o  output  1  R[0] of the applied code
- done_o  output  1  one-cycle pulse when the applied code reaches the target

## Operation
- Registers:
  - cur: applied code, N bits
  - tgt: target code, N bits
  - busy: 1 bit
- Accept: on an edge with code_valid_i & code_ready_o, tgt <= code_i and busy <= 1.
- code_ready_o = ~busy (registered). No accept occurs while busy; code_i is ignored then.
- Step on each edge where busy & ~hold_i:
  - ramp_en_i = 1: cur moves toward tgt by min(|tgt-cur|, STEP_MAX).
  - ramp_en_i = 0: cur <= tgt.
  - Difference is computed in N+1 bits, signed. cur never overshoots tgt and never wraps.
- Completion: on the edge where cur becomes equal to tgt, busy <= 0 and done_o <= 1 for one cycle.
- Equal code: if an accepted code equals cur, the next edge clears busy and pulses done_o. cur does not change.
- Decode, from cur with R = cur[N-1:COL_W] and c = cur[COL_W-1:0]:
  - row_full_o: bit r = 1 for all r < R.
  - row_act_o: bit R only.
  - Even R: col_o has ones at bits [c-1:0]. An active-row cell is on where col_o = 1.
  - Odd R: col_o has ones at bits [2^COL_W-c-1:0]. An active-row cell is on where col_o = 0, so the fill runs in reverse (serpentine).
  - Total cells on always equals cur.
- Outputs are registered from the next value of cur, so they change on the same edge as cur.
- ramp_en_i and hold_i are sampled every edge. Changing ramp_en_i mid-ramp takes effect on the next step.
- Reset (rst_n = 0 at an edge), for every output:
  - row_full_o = 0
  - row_act_o = 1 (bit 0)
  - col_o = 0
  - row_odd_o = 0
  - done_o = 0
  - code_ready_o = 1
  - cur = 0 and tgt = 0
- Reset mid-ramp aborts the ramp and applies the values above at that edge. No done_o is issued.

## Timing
- Accept edge E0. First step at E0+1.
- With ramp_en_i = 1 and no hold, the final step is at E0 + ceil(|tgt-cur|/STEP_MAX). done_o is high in the cycle after the final step edge. code_ready_o is 1 from that same edge.
- With ramp_en_i = 0: cur = tgt at E0+1.
- hold_i = 1 inserts stall cycles 1:1. A hold during the final step delays completion.
- Maximum per-edge output change: STEP_MAX cells, except on reset.
- Row boundary (c wraps 2^COL_W-1 -> 0):
  - row_full_o gains bit R.
  - row_act_o shifts up one bit.
  - row_odd_o toggles.
  - All of these change on the same edge.
- cur = 2^N-1: R = 2^ROW_W-1, all lower rows full.

## Test plan
- Reset, then ramp: release rst_n, accept code 0x13 with ramp_en_i = 1 and STEP_MAX = 1 -> 19 step edges, cur = 0x13, row_full_o = 0x0001, row_act_o = 0x0002, row_odd_o = 1, col_o = 0x1FFF, one done_o pulse.
- Jump mode, downward: with ramp_en_i = 0, from 0xFF accept 0x00 -> one edge later row_full_o = 0, col_o = 0, row_act_o = 0x0001, done_o pulse.
- STEP_MAX = 5: from 0x00 accept 0x0C -> cur sequence 0x05, 0x0A, 0x0C, no overshoot, done_o after the third step.
- Handshake: assert code_valid_i while busy -> code ignored, tgt unchanged. A code equal to cur -> busy for one cycle, done_o pulse, outputs unchanged.
- Hold and reset mid-ramp: assert hold_i for 3 cycles mid-ramp -> cur frozen and completion delayed by 3 cycles. Drop rst_n mid-ramp -> reset values at that edge, no done_o.
- Exhaustive serpentine check: ramp 0 -> 2^N-1 with STEP_MAX = 1 -> each edge changes the cell count by exactly 1, and on-cells equal cur per the decode rule.

Source files
------------

// File: rtl/flb_therm_ramp_decoder_if.sv
// Code handshake and decoded cell-matrix lines between the DPLL loop filter
// and the FLB row/column thermometer decoder.
interface flb_therm_ramp_decoder_if #(
  parameter int ROW_W = 4,
  parameter int COL_W = 4
);
  localparam int N  = ROW_W + COL_W;
  localparam int NR = 1 << ROW_W;
  localparam int NC = 1 << COL_W;

  logic [N-1:0]  code_i;
  logic          code_valid_i;
  logic          code_ready_o;
  logic          ramp_en_i;
  logic          hold_i;
  logic [NR-1:0] row_full_o;
  logic [NR-1:0] row_act_o;
  logic [NC-1:0] col_o;
  logic          row_odd_o;
  logic          done_o;

  modport master (
    output code_i, code_valid_i, ramp_en_i, hold_i,
    input  code_ready_o, row_full_o, row_act_o, col_o, row_odd_o, done_o
  );

  modport slave (
    input  code_i, code_valid_i, ramp_en_i, hold_i,
    output code_ready_o, row_full_o, row_act_o, col_o, row_odd_o, done_o
  );
endinterface

// File: rtl/flb_therm_ramp_decoder.sv
// Slew-limited binary to serpentine row/column thermometer decoder for the
// FLB DCO unit-cell matrix; all matrix lines are registered.
module flb_therm_ramp_decoder #(
  parameter int ROW_W    = 4,
  parameter int COL_W    = 4,
  parameter int STEP_MAX = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  flb_therm_ramp_decoder_if.slave  bus
);
  localparam int N  = ROW_W + COL_W;
  localparam int NR = 1 << ROW_W;
  localparam int NC = 1 << COL_W;
  localparam logic [N-1:0] STEP_N = N'(STEP_MAX);

  logic [N-1:0]      r_cur;
  logic [N-1:0]      r_tgt;
  logic              r_busy;
  logic              r_done;
  logic [NR-1:0]     r_row_full;
  logic [NR-1:0]     r_row_act;
  logic [NC-1:0]     r_col;
  logic              r_row_odd;

  logic signed [N:0] w_diff;
  logic [N:0]        w_mag;
  logic              w_step;
  logic              w_accept;
  logic [N-1:0]      w_cur_nxt;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_colc;

  function automatic logic [NR-1:0] f_row_full(input logic [ROW_W-1:0] r);
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = (i < int'(r));
    return v;
  endfunction

  function automatic logic [NR-1:0] f_row_act(input logic [ROW_W-1:0] r);
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = (i == int'(r));
    return v;
  endfunction

  // Odd rows fill from the far end: cells are on where the line is low.
  function automatic logic [NC-1:0] f_col(input logic odd, input logic [COL_W-1:0] c);
    logic [NC-1:0] v;
    int            ones;
    ones = odd ? (NC - int'(c)) : int'(c);
    for (int i = 0; i < NC; i++) v[i] = (i < ones);
    return v;
  endfunction

  always_comb begin
    w_diff    = $signed({1'b0, r_tgt}) - $signed({1'b0, r_cur});
    w_mag     = w_diff[N] ? $unsigned(-w_diff) : $unsigned(w_diff);
    w_step    = r_busy & ~bus.hold_i;
    w_accept  = ~r_busy & bus.code_valid_i;
    w_cur_nxt = r_cur;
    if (w_step) begin
      if (bus.ramp_en_i && (w_mag > {1'b0, STEP_N}))
        w_cur_nxt = w_diff[N] ? (r_cur - STEP_N) : (r_cur + STEP_N);
      else
        w_cur_nxt = r_tgt;
    end
    w_row  = w_cur_nxt[N-1:COL_W];
    w_colc = w_cur_nxt[COL_W-1:0];
  end

  // Stage boundary: applied code, handshake state and decoded lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur      <= '0;
      r_tgt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_row_full <= '0;
      r_row_act  <= NR'(1);
      r_col      <= '0;
      r_row_odd  <= 1'b0;
    end else begin
      r_cur  <= w_cur_nxt;
      r_done <= 1'b0;
      if (w_step && (w_cur_nxt == r_tgt)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_accept) begin
        r_tgt  <= bus.code_i;
        r_busy <= 1'b1;
      end
      r_row_full <= f_row_full(w_row);
      r_row_act  <= f_row_act(w_row);
      r_col      <= f_col(w_row[0], w_colc);
      r_row_odd  <= w_row[0];
    end
  end

  assign bus.code_ready_o = ~r_busy;
  assign bus.row_full_o   = r_row_full;
  assign bus.row_act_o    = r_row_act;
  assign bus.col_o        = r_col;
  assign bus.row_odd_o    = r_row_odd;
  assign bus.done_o       = r_done;
endmodule
